// File: rtl/naneye_pkg.sv
// Shared definitions for the NanEye pixel stream formatter: FSM encoding,
// default geometry and the bit positions of the sticky error flags.
package naneye_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_IN_LINE   = 2'd2
    } fmt_state_t;

    localparam int DEF_D_WIDTH     = 10;
    localparam int DEF_C_COLUMNS   = 250;
    localparam int DEF_C_ROWS      = 250;
    localparam int DEF_FIFO_DEPTH  = 16;
    localparam int FRAME_CNT_WIDTH = 16;

    localparam int FLAG_COUNT          = 2;
    localparam int FLAG_FIFO_OVERFLOW  = 0;
    localparam int FLAG_LINE_LEN_ERROR = 1;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible whenever the FIFO
// is not empty; a push into a full FIFO only lands if a pop happens alongside.
module pixel_fifo
    import naneye_pkg::*;
#(
    parameter int WIDTH = DEF_D_WIDTH + 2,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             dropped
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dropped = push && !do_push;

    // Gate the head with empty so the outputs read as zero with nothing buffered.
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_stream_fmt.sv
// Turns the DPRAM read stream plus H/V sync into a valid/ready pixel stream
// tagged with start-of-frame and end-of-line, buffered through pixel_fifo.
module pixel_stream_fmt
    import naneye_pkg::*;
#(
    parameter int D_WIDTH    = DEF_D_WIDTH,
    parameter int C_COLUMNS  = DEF_C_COLUMNS,
    parameter int C_ROWS     = DEF_C_ROWS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic                       RDAT_VALID,
    input  logic [D_WIDTH-1:0]         PAR_INPUT,
    input  logic                       H_SYNC,
    input  logic                       V_SYNC,
    input  logic                       M_READY,
    output logic                       M_VALID,
    output logic [D_WIDTH-1:0]         M_DATA,
    output logic                       M_SOF,
    output logic                       M_EOL,
    output logic                       FIFO_OVERFLOW,
    output logic                       LINE_LEN_ERROR,
    output logic [FRAME_CNT_WIDTH-1:0] FRAME_CNT
);

    localparam int COL_W = $clog2(C_COLUMNS + 1);
    localparam int ROW_W = $clog2(C_ROWS + 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(C_COLUMNS - 1);
    localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(C_COLUMNS);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(C_ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
    localparam logic [FRAME_CNT_WIDTH-1:0] FRAME_ONE = FRAME_CNT_WIDTH'(1);

    fmt_state_t state;
    fmt_state_t next_state;

    logic                       h_sync_q;
    logic                       v_sync_q;
    logic                       sync_primed;
    logic                       rdat_valid_q;
    logic                       h_rise;
    logic                       v_rise;
    logic                       pixel_cycle;
    logic [COL_W-1:0]           col_cnt;
    logic [ROW_W-1:0]           row_cnt;
    logic                       last_col;
    logic                       last_row;
    logic                       sof_armed;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
    logic [FLAG_COUNT-1:0]      sticky_flags;

    logic                       pix_accept;
    logic                       line_start;
    logic                       short_line;
    logic                       stray_pixel;
    logic                       line_done;

    logic [D_WIDTH+1:0]         fifo_head;
    logic                       fifo_empty;
    logic                       fifo_pop;
    logic                       fifo_drop;

    // sync_primed masks the first cycle after reset so a sync already high
    // at release is taken as history rather than as a rising edge.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            h_sync_q     <= 1'b0;
            v_sync_q     <= 1'b0;
            sync_primed  <= 1'b0;
            rdat_valid_q <= 1'b0;
        end else begin
            h_sync_q     <= H_SYNC;
            v_sync_q     <= V_SYNC;
            sync_primed  <= 1'b1;
            rdat_valid_q <= RDAT_VALID;
        end
    end

    assign h_rise      = sync_primed && H_SYNC && !h_sync_q;
    assign v_rise      = sync_primed && V_SYNC && !v_sync_q;
    assign pixel_cycle = rdat_valid_q;
    assign last_col    = (col_cnt == LAST_COL);
    assign last_row    = (row_cnt == LAST_ROW);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // V_SYNC overrides everything else, whatever state the line logic is in.
    always_comb begin
        next_state = state;
        if (v_rise) begin
            next_state = ST_WAIT_LINE;
        end else begin
            case (state)
                ST_IDLE: begin
                    next_state = ST_IDLE;
                end
                ST_WAIT_LINE: begin
                    if (h_rise) begin
                        next_state = ST_IN_LINE;
                    end
                end
                ST_IN_LINE: begin
                    if (!h_rise && pixel_cycle && last_col) begin
                        next_state = last_row ? ST_IDLE : ST_WAIT_LINE;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        pix_accept  = 1'b0;
        line_start  = 1'b0;
        short_line  = 1'b0;
        stray_pixel = 1'b0;
        if (!v_rise) begin
            case (state)
                ST_WAIT_LINE: begin
                    line_start  = h_rise;
                    stray_pixel = pixel_cycle;
                end
                ST_IN_LINE: begin
                    short_line = h_rise && (col_cnt < COL_LIMIT);
                    pix_accept = pixel_cycle && !h_rise;
                end
                default: begin
                    pix_accept = 1'b0;
                end
            endcase
        end
    end

    assign line_done = pix_accept && last_col;

    // Counters keep advancing on accepted pixels even if the FIFO drops them.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            sof_armed <= 1'b0;
            frame_cnt <= '0;
        end else if (v_rise) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            sof_armed <= 1'b1;
            frame_cnt <= frame_cnt + FRAME_ONE;
        end else begin
            if (line_start) begin
                col_cnt <= '0;
            end
            if (short_line) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + ROW_ONE;
            end
            if (pix_accept) begin
                col_cnt   <= col_cnt + COL_ONE;
                sof_armed <= 1'b0;
                if (line_done) begin
                    row_cnt <= row_cnt + ROW_ONE;
                end
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sticky_flags <= '0;
        end else begin
            if (fifo_drop) begin
                sticky_flags[FLAG_FIFO_OVERFLOW] <= 1'b1;
            end
            if (short_line || stray_pixel) begin
                sticky_flags[FLAG_LINE_LEN_ERROR] <= 1'b1;
            end
        end
    end

    assign fifo_pop = M_VALID && M_READY;

    pixel_fifo #(
        .WIDTH (D_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_pixel_fifo (
        .clock     (CLOCK),
        .reset     (RESET),
        .push      (pix_accept),
        .push_data ({sof_armed, last_col, PAR_INPUT}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .dropped   (fifo_drop)
    );

    assign M_VALID        = !fifo_empty;
    assign M_SOF          = fifo_head[D_WIDTH+1];
    assign M_EOL          = fifo_head[D_WIDTH];
    assign M_DATA         = fifo_head[D_WIDTH-1:0];
    assign FIFO_OVERFLOW  = sticky_flags[FLAG_FIFO_OVERFLOW];
    assign LINE_LEN_ERROR = sticky_flags[FLAG_LINE_LEN_ERROR];
    assign FRAME_CNT      = frame_cnt;

endmodule

// File: tb/tb_pixel_stream_fmt.sv
// Scoreboard bench for pixel_stream_fmt: stimulus tasks queue the expected
// beats, a forked monitor pops and compares every accepted output beat.
module tb_pixel_stream_fmt;

    localparam int DW    = 10;
    localparam int COLS  = 250;
    localparam int ROWS  = 250;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          rdat_valid;
    logic [DW-1:0] par_input;
    logic          h_sync;
    logic          v_sync;
    logic          m_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_sof;
    logic          m_eol;
    logic          fifo_overflow;
    logic          line_len_error;
    logic [15:0]   frame_cnt;

    int            errors = 0;
    int            checks = 0;
    logic [DW+1:0] exp_q[$];
    logic [DW-1:0] pending_pix = '0;

    always #5 clock = ~clock;

    pixel_stream_fmt #(
        .D_WIDTH    (DW),
        .C_COLUMNS  (COLS),
        .C_ROWS     (ROWS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLOCK          (clock),
        .RESET          (reset),
        .RDAT_VALID     (rdat_valid),
        .PAR_INPUT      (par_input),
        .H_SYNC         (h_sync),
        .V_SYNC         (v_sync),
        .M_READY        (m_ready),
        .M_VALID        (m_valid),
        .M_DATA         (m_data),
        .M_SOF          (m_sof),
        .M_EOL          (m_eol),
        .FIFO_OVERFLOW  (fifo_overflow),
        .LINE_LEN_ERROR (line_len_error),
        .FRAME_CNT      (frame_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // The pixel for a read strobe follows one cycle later on PAR_INPUT.
    task automatic applyStimulus(input logic rv, input logic hs, input logic vs,
                                 input logic rdy, input logic [DW-1:0] pix);
        @(posedge clock);
        #1;
        par_input   = pending_pix;
        pending_pix = pix;
        rdat_valid  = rv;
        h_sync      = hs;
        v_sync      = vs;
        m_ready     = rdy;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, rdy, '0);
    endtask

    task automatic sendPixel(input logic [DW-1:0] pix, input logic rdy, input logic expect_beat,
                             input logic sof, input logic eol);
        applyStimulus(1'b1, 1'b0, 1'b0, rdy, pix);
        if (expect_beat) exp_q.push_back({sof, eol, pix});
    endtask

    task automatic frameStart(input logic rdy);
        applyStimulus(1'b0, 1'b0, 1'b1, rdy, '0);
        idle(1, rdy);
    endtask

    task automatic lineStart(input logic rdy);
        applyStimulus(1'b0, 1'b1, 1'b0, rdy, '0);
        idle(1, rdy);
    endtask

    task automatic sendLine(input int n, input int base, input logic sof_first,
                            input logic eol_last, input logic expect_beats);
        for (int i = 0; i < n; i++) begin
            sendPixel(DW'(base + i), 1'b1, expect_beats, sof_first && (i == 0), eol_last && (i == n - 1));
        end
        idle(1, 1'b1);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            idle(1, 1'b1);
            n++;
        end
        idle(2, 1'b1);
        checkOutput("drain_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic resetDut(input logic hs, input logic vs);
        @(posedge clock);
        #1;
        reset      = 1'b1;
        rdat_valid = 1'b0;
        h_sync     = hs;
        v_sync     = vs;
        m_ready    = 1'b0;
        @(posedge clock);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        checkOutput({tag, "_m_data"}, 32'(m_data), 32'd0);
        checkOutput({tag, "_m_sof"}, 32'(m_sof), 32'd0);
        checkOutput({tag, "_m_eol"}, 32'(m_eol), 32'd0);
        checkOutput({tag, "_overflow"}, 32'(fifo_overflow), 32'd0);
        checkOutput({tag, "_line_len"}, 32'(line_len_error), 32'd0);
        checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    task automatic monitorBeats();
        logic [DW+1:0] exp_beat;
        forever begin
            @(negedge clock);
            if (!reset && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no beat", {m_sof, m_eol, m_data});
                end else begin
                    exp_beat = exp_q.pop_front();
                    checkOutput("beat", 32'({m_sof, m_eol, m_data}), 32'(exp_beat));
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        rdat_valid = 1'b0;
        par_input  = '0;
        h_sync     = 1'b0;
        v_sync     = 1'b0;
        m_ready    = 1'b0;
        fork
            monitorBeats();
        join_none

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        idle(2, 1'b0);
        @(negedge clock);
        checkResetOutputs("por");

        $display("[TB] full frame with M_READY held high");
        frameStart(1'b1);
        for (int r = 0; r < ROWS; r++) begin
            lineStart(1'b1);
            sendLine(COLS, r * 3, r == 0, 1'b1, 1'b1);
            if (r == 0) begin
                waitDrain(50);
                checkOutput("line1_frame_cnt", 32'(frame_cnt), 32'd1);
                checkOutput("line1_overflow", 32'(fifo_overflow), 32'd0);
                checkOutput("line1_line_len", 32'(line_len_error), 32'd0);
            end
        end
        lineStart(1'b1);
        sendLine(10, 500, 1'b0, 1'b0, 1'b0);
        waitDrain(50);
        @(negedge clock);
        checkOutput("after_frame_no_beats", 32'(m_valid), 32'd0);
        checkOutput("after_frame_line_len", 32'(line_len_error), 32'd0);
        checkOutput("after_frame_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("[TB] short line followed by a full line");
        frameStart(1'b1);
        lineStart(1'b1);
        sendLine(100, 7, 1'b1, 1'b0, 1'b1);
        lineStart(1'b1);
        sendLine(COLS, 11, 1'b0, 1'b1, 1'b1);
        waitDrain(50);
        checkOutput("short_line_len_err", 32'(line_len_error), 32'd1);
        checkOutput("short_line_overflow", 32'(fifo_overflow), 32'd0);
        checkOutput("short_line_frame_cnt", 32'(frame_cnt), 32'd2);

        $display("[TB] overflow with M_READY low");
        frameStart(1'b0);
        lineStart(1'b0);
        for (int i = 0; i < 20; i++) begin
            sendPixel(DW'(100 + i), 1'b0, i < DEPTH, i == 0, 1'b0);
        end
        idle(3, 1'b0);
        @(negedge clock);
        checkOutput("ovf_m_valid", 32'(m_valid), 32'd1);
        checkOutput("ovf_m_data", 32'(m_data), 32'd100);
        checkOutput("ovf_m_sof", 32'(m_sof), 32'd1);
        checkOutput("ovf_flag", 32'(fifo_overflow), 32'd1);
        idle(2, 1'b0);
        @(negedge clock);
        checkOutput("ovf_m_data_held", 32'(m_data), 32'd100);
        waitDrain(100);
        checkOutput("ovf_frame_cnt", 32'(frame_cnt), 32'd3);

        $display("[TB] push into full FIFO with simultaneous pop");
        resetDut(1'b0, 1'b0);
        #1 reset = 1'b0;
        idle(2, 1'b0);
        @(negedge clock);
        checkOutput("rst2_overflow", 32'(fifo_overflow), 32'd0);
        checkOutput("rst2_frame_cnt", 32'(frame_cnt), 32'd0);
        frameStart(1'b0);
        lineStart(1'b0);
        sendPixel(DW'(200), 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        @(negedge clock);
        checkOutput("latency_one_cycle", 32'(m_valid), 32'd0);
        sendPixel(DW'(201), 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("latency_two_cycles", 32'(m_valid), 32'd1);
        for (int i = 2; i < DEPTH; i++) begin
            sendPixel(DW'(200 + i), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        idle(3, 1'b0);
        @(negedge clock);
        checkOutput("full_no_overflow", 32'(fifo_overflow), 32'd0);
        checkOutput("full_head", 32'(m_data), 32'd200);
        sendPixel(DW'(216), 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clock);
        checkOutput("swap_no_overflow", 32'(fifo_overflow), 32'd0);
        checkOutput("swap_m_valid", 32'(m_valid), 32'd1);
        checkOutput("swap_head", 32'(m_data), 32'd201);
        waitDrain(100);
        checkOutput("swap_overflow_after_drain", 32'(fifo_overflow), 32'd0);

        $display("[TB] reset mid-line with buffered pixels");
        frameStart(1'b0);
        lineStart(1'b0);
        for (int i = 0; i < 5; i++) begin
            sendPixel(DW'(300 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(3, 1'b0);
        @(negedge clock);
        checkOutput("pre_reset_m_valid", 32'(m_valid), 32'd1);
        resetDut(1'b1, 1'b1);
        @(negedge clock);
        checkResetOutputs("midline");
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, '0);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, DW'(400));
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, '0);
        @(negedge clock);
        checkOutput("held_sync_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("held_sync_m_valid", 32'(m_valid), 32'd0);
        checkOutput("held_sync_line_len", 32'(line_len_error), 32'd0);
        idle(3, 1'b1);

        checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_stream_fmt.md
PIXEL_STREAM_FMT -- requirements
Module: pixel_stream_fmt

Interface
REQ-001 SHALL have parameter D_WIDTH, default 10, pixel width.
REQ-002 SHALL have parameter C_COLUMNS, default 250, pixels per line.
REQ-003 SHALL have parameter C_ROWS, default 250, lines per frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, power of two, output buffer entries.
REQ-005 SHALL have port CLOCK  in  1  the single clock (48 MHz system domain); all logic on its rising edge.
REQ-006 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-007 SHALL have port RDAT_VALID  in  1  DPRAM read-valid strobe from the read controller.
REQ-008 SHALL have port PAR_INPUT  in  D_WIDTH  registered pixel from the output register, valid the cycle after RDAT_VALID.
REQ-009 SHALL have port H_SYNC  in  1  line sync; rising edge = line start.
REQ-010 SHALL have port V_SYNC  in  1  frame sync; rising edge = frame start.
REQ-011 SHALL have port M_READY  in  1  downstream ready.
REQ-012 SHALL have port M_VALID  out  1  stream beat valid.
REQ-013 SHALL have port M_DATA  out  D_WIDTH  pixel.
REQ-014 SHALL have port M_SOF  out  1  first pixel of frame.
REQ-015 SHALL have port M_EOL  out  1  last pixel of line.
REQ-016 SHALL have port FIFO_OVERFLOW  out  1  sticky, pixel dropped on full buffer.
REQ-017 SHALL have port LINE_LEN_ERROR  out  1  sticky, line length != C_COLUMNS.
REQ-018 SHALL have port FRAME_CNT  out  16  count of V_SYNC rising edges, wraps 0xFFFF->0.

Function
REQ-019 SHALL detect H_SYNC/V_SYNC rising edges against a one-cycle registered copy.
REQ-020 SHALL delay RDAT_VALID by one cycle and capture PAR_INPUT in that delayed cycle (the pixel cycle).
REQ-021 SHALL implement FSM IDLE, WAIT_LINE, IN_LINE; IDLE after reset.
REQ-022 SHALL on V_SYNC rise in any state clear row/column counters, arm SOF, increment FRAME_CNT, enter WAIT_LINE; V_SYNC wins over simultaneous H_SYNC or pixel.
REQ-023 SHALL in WAIT_LINE on H_SYNC rise clear column counter and enter IN_LINE.
REQ-024 SHALL in IN_LINE accept each pixel cycle, increment column; pixel number C_COLUMNS tagged EOL, row incremented, next state WAIT_LINE, or IDLE when row reaches C_ROWS.
REQ-025 SHALL tag the first accepted pixel after SOF is armed with SOF, then disarm.
REQ-026 SHALL on H_SYNC rise in IN_LINE with column < C_COLUMNS set LINE_LEN_ERROR, count the short line as a row, restart column at 0, stay in IN_LINE; no EOL emitted for the short line.
REQ-027 SHALL discard pixel cycles in IDLE or WAIT_LINE; in WAIT_LINE such a pixel sets LINE_LEN_ERROR.
REQ-028 SHALL write {SOF, EOL, pixel} into the FIFO in the pixel cycle; M_VALID asserts two cycles after RDAT_VALID when FIFO was empty.
REQ-029 SHALL present FIFO head show-ahead: M_VALID = not empty; M_DATA/M_SOF/M_EOL stable while M_VALID and not M_READY.
REQ-030 SHALL pop on M_VALID and M_READY in the same cycle.
REQ-031 SHALL accept a write when full only if a pop occurs the same cycle; otherwise drop the pixel, set FIFO_OVERFLOW; FSM counters still advance.
REQ-032 SHALL keep occupancy correct on simultaneous push/pop at any level; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-033 SHALL on RESET: FSM IDLE, counters 0, FIFO empty, M_VALID 0, M_DATA 0, M_SOF 0, M_EOL 0, FIFO_OVERFLOW 0, LINE_LEN_ERROR 0, FRAME_CNT 0, sync history 0.
REQ-034 SHALL, when RESET asserts mid-line, discard buffered pixels; an H/V_SYNC already high at release is not an edge.

Structure
REQ-035 SHALL place state encoding, default widths and sticky-flag bit indices in shared package naneye_pkg.
REQ-036 SHALL instantiate one sub-module pixel_fifo (synchronous, show-ahead, width D_WIDTH+2, depth FIFO_DEPTH).

Verification
REQ-037 SHALL cover: V rise, H rise, 250 pixels, M_READY=1 -> 250 beats, first SOF, last EOL, FRAME_CNT=1, no flags.
REQ-038 SHALL cover: full 250x250 frame -> 250 EOL beats, FSM IDLE after row 250, further pixels dropped.
REQ-039 SHALL cover: line of 100 pixels then H rise -> LINE_LEN_ERROR=1, next 250-pixel line ends with EOL.
REQ-040 SHALL cover: M_READY=0, 20 pixels, depth 16 -> 16 beats kept, FIFO_OVERFLOW=1, M_DATA held.
REQ-041 SHALL cover: FIFO full, M_READY=1, pixel same cycle -> push accepted, no overflow, occupancy 16.
REQ-042 SHALL cover: RESET mid-line with 5 buffered -> M_VALID=0 next cycle, all outputs at reset values.
